// File: rtl/ex_mem_stage.sv
// Execute stage (forwarding muxes, ALU, destination select) and the EX/MEM pipeline register.
// Optional macro OVERFLOW_TRAP_EN: signed-overflow detection that suppresses the register write.
module ex_mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic              ALUSrcE,
  input  logic              RegDstE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] SignImmE,
  input  logic [4:0]        RT_E,
  input  logic [4:0]        RD_E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic [4:0]        WriteRegE,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [4:0]        WriteRegM,
  output logic              OverflowM
);

  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] srcB;
  logic [DATA_W-1:0] aluRes;
  logic              regWriteNext;

  // ALUOutM feeds back on select 10, giving a back-to-back dependent chain
  always_comb begin
    srcA = RD1_E;
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUOutM;
      default: srcA = RD1_E;
    endcase
  end

  always_comb begin
    fwdB = RD2_E;
    case (ForwardBE)
      2'b01:   fwdB = ResultW;
      2'b10:   fwdB = ALUOutM;
      default: fwdB = RD2_E;
    endcase
  end

  assign srcB      = ALUSrcE ? SignImmE : fwdB;
  assign WriteRegE = RegDstE ? RD_E : RT_E;

  always_comb begin
    aluRes = '0;
    case (ALUControlE)
      3'b010:  aluRes = srcA + srcB;
      3'b110:  aluRes = srcA - srcB;
      3'b000:  aluRes = srcA & srcB;
      3'b001:  aluRes = srcA | srcB;
      3'b111:  aluRes = {{(DATA_W-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: aluRes = '0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    case (ALUControlE)
      3'b010:  ovf = (srcA[DATA_W-1] == srcB[DATA_W-1]) && (aluRes[DATA_W-1] != srcA[DATA_W-1]);
      3'b110:  ovf = (srcA[DATA_W-1] != srcB[DATA_W-1]) && (aluRes[DATA_W-1] != srcA[DATA_W-1]);
      default: ovf = 1'b0;
    endcase
  end

  assign regWriteNext = RegWriteE & ~ovf;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) OverflowM <= 1'b0;
    else        OverflowM <= ovf;
  end
`else
  assign regWriteNext = RegWriteE;
  assign OverflowM    = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      RegWriteM  <= regWriteNext;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= aluRes;
      WriteDataM <= fwdB;
      WriteRegM  <= WriteRegE;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios, async reset, then randomized traffic vs. a reference model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, SignImmE, ResultW;
  logic [4:0]  RT_E, RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [4:0]  WriteRegE;
  logic        RegWriteM, MemtoRegM, MemWriteM, OverflowM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  int errCnt = 0;
  int chkCnt = 0;
  logic [31:0] modelAlu = '0;

  ex_mem_stage #(.DATA_W(32)) dut (
    .clk(clk), .clr_n(clr_n),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImmE(SignImmE),
    .RT_E(RT_E), .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .OverflowM(OverflowM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
    chk({tag, ".MemtoRegM"}, {31'd0, MemtoRegM}, 32'd0);
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
    chk({tag, ".OverflowM"}, {31'd0, OverflowM}, 32'd0);
    chk({tag, ".ALUOutM"}, ALUOutM, 32'd0);
    chk({tag, ".WriteDataM"}, WriteDataM, 32'd0);
    chk({tag, ".WriteRegM"}, {27'd0, WriteRegM}, 32'd0);
  endtask

  task automatic setIdle();
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUSrcE = 0; RegDstE = 0;
    ALUControlE = 3'b010; RD1_E = 0; RD2_E = 0; SignImmE = 0; ResultW = 0;
    RT_E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  // Reference: evaluate the instruction from its architectural meaning, clock, compare.
  task automatic cycle(input string tag);
    logic [31:0] a, fb, b, res;
    longint sa, sb, wide;
    bit ovf, trap;
    logic [4:0] dst;
    a  = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? modelAlu : RD1_E;
    fb = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? modelAlu : RD2_E;
    b  = ALUSrcE ? SignImmE : fb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 0;
    case (ALUControlE)
      3'b010: begin wide = sa + sb; res = a + b; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      3'b110: begin wide = sa - sb; res = a - b; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
`ifdef OVERFLOW_TRAP_EN
    trap = 1;
`else
    trap = 0;
`endif
    dst = RegDstE ? RD_E : RT_E;
    #1;
    chk({tag, ".WriteRegE"}, {27'd0, WriteRegE}, {27'd0, dst});
    @(posedge clk);
    #1;
    chk({tag, ".ALUOutM"}, ALUOutM, res);
    chk({tag, ".WriteDataM"}, WriteDataM, fb);
    chk({tag, ".WriteRegM"}, {27'd0, WriteRegM}, {27'd0, dst});
    chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, (trap && ovf) ? 1'b0 : RegWriteE});
    chk({tag, ".MemtoRegM"}, {31'd0, MemtoRegM}, {31'd0, MemtoRegE});
    chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, MemWriteE});
    chk({tag, ".OverflowM"}, {31'd0, OverflowM}, {31'd0, trap && ovf});
    modelAlu = res;
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'h7FFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    clr_n = 1'b0;
    setIdle();
    #3;
    chkZero("reset");
    @(posedge clk); #1;
    chkZero("resetHeld");
    clr_n = 1'b1;

    // add 5+7
    RegWriteE = 1; ALUControlE = 3'b010; RD1_E = 5; RD2_E = 7;
    cycle("add57");
    chk("add57.value", ALUOutM, 32'd12);

    // immediate add with store, RT selected
    setIdle();
    RegDstE = 0; RT_E = 9; RD_E = 3; ALUSrcE = 1; SignImmE = 32'hFFFF_FFFC;
    RD1_E = 32'h10; MemWriteE = 1;
    cycle("addImm");
    chk("addImm.value", ALUOutM, 32'h0C);

    // dependent chain through ALUOutM with ResultW on the other operand
    setIdle();
    RD1_E = 1; RD2_E = 1; RegWriteE = 1;
    cycle("chain1");
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 40; RD1_E = 99; RD2_E = 77;
    cycle("chain2");
    chk("chain2.value", ALUOutM, 32'd42);

    // SLT across the sign boundary, both orders
    setIdle();
    ALUControlE = 3'b111; RD1_E = 32'h8000_0000; RD2_E = 32'h7FFF_FFFF;
    cycle("slt");
    chk("slt.value", ALUOutM, 32'd1);
    RD1_E = 32'h7FFF_FFFF; RD2_E = 32'h8000_0000;
    cycle("sltSwap");
    chk("sltSwap.value", ALUOutM, 32'd0);

    // signed overflow on add
    setIdle();
    RegWriteE = 1; RD1_E = 32'h7FFF_FFFF; RD2_E = 1;
    cycle("addOvf");
    chk("addOvf.value", ALUOutM, 32'h8000_0000);

    // undefined op code and sub
    ALUControlE = 3'b011;
    cycle("opUndef");
    ALUControlE = 3'b110; RD1_E = 32'h8000_0000; RD2_E = 1;
    cycle("subOvf");

    // asynchronous reset between edges, in-flight instruction discarded
    setIdle();
    RegWriteE = 1; MemWriteE = 1; MemtoRegE = 1; RD1_E = 3; RD2_E = 4; RT_E = 5;
    cycle("preReset");
    #2;
    clr_n = 1'b0;
    #1;
    chkZero("asyncClr");
    @(posedge clk); #1;
    chkZero("clrEdge");
    #2;
    clr_n = 1'b1;
    #1;
    chkZero("clrRelease");
    modelAlu = '0;
    cycle("postReset");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      RegWriteE   = 1'($urandom_range(0, 1));
      MemtoRegE   = 1'($urandom_range(0, 1));
      MemWriteE   = 1'($urandom_range(0, 1));
      ALUSrcE     = 1'($urandom_range(0, 1));
      RegDstE     = 1'($urandom_range(0, 1));
      ALUControlE = 3'($urandom_range(0, 7));
      RD1_E       = randOperand();
      RD2_E       = randOperand();
      SignImmE    = randOperand();
      ResultW     = randOperand();
      RT_E        = 5'($urandom_range(0, 31));
      RD_E        = 5'($urandom_range(0, 31));
      ForwardAE   = 2'($urandom_range(0, 3));
      ForwardBE   = 2'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of operands, immediate, result and store data.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port clr_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  in  1 each  execute-stage control bits.
REQ-005 SHALL have port ALUControlE  in  3  ALU operation select.
REQ-006 SHALL have ports RD1_E, RD2_E, SignImmE  in  DATA_W each  register operands and sign-extended immediate.
REQ-007 SHALL have ports RT_E, RD_E  in  5 each  destination register candidates.
REQ-008 SHALL have ports ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
REQ-009 SHALL have port ResultW  in  DATA_W  writeback-stage result for forwarding.
REQ-010 SHALL have port WriteRegE  out  5  combinational destination register for the hazard unit.
REQ-011 SHALL have ports RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered control bits.
REQ-012 SHALL have ports ALUOutM, WriteDataM  out  DATA_W each  registered ALU result and store data.
REQ-013 SHALL have port WriteRegM  out  5  registered destination register.
REQ-014 SHALL have port OverflowM  out  1  registered signed-overflow flag.

Function
REQ-015 SrcA SHALL be RD1_E for ForwardAE=00, ResultW for 01, ALUOutM (this block's own registered output) for 10, and RD1_E for 11.
REQ-016 The forwarded B operand SHALL be selected from RD2_E, ResultW or ALUOutM by ForwardBE under the same encoding as REQ-015.
REQ-017 SrcB SHALL be SignImmE when ALUSrcE=1, otherwise the forwarded B operand.
REQ-018 The ALU SHALL implement ALUControlE 010 add, 110 sub, 000 AND, 001 OR, and 111 SLT (1 if $signed(SrcA) < $signed(SrcB), else 0).
REQ-019 The ALU SHALL output 0 for any other ALUControlE code.
REQ-020 Add and subtract SHALL be modulo 2^DATA_W (wrap-around, no carry out).
REQ-021 SLT SHALL be correct across overflow, e.g. 0x80000000 < 0x7FFFFFFF gives 1.
REQ-022 WriteRegE SHALL be RD_E when RegDstE=1, otherwise RT_E, with no register in the path.
REQ-023 Signed overflow SHALL be detected for add (operand signs equal, result sign differs) and for sub (operand signs differ, result sign differs from SrcA); all other ops SHALL report no overflow.
REQ-024 Each rising clk SHALL load RegWriteM, MemtoRegM, MemWriteM, ALU result into ALUOutM, forwarded B operand (before the ALUSrc mux) into WriteDataM, WriteRegE into WriteRegM, and the overflow flag into OverflowM.
REQ-025 Latency from E inputs to M outputs SHALL be exactly one cycle, with no stall or bubble logic; one instruction SHALL be accepted per cycle.
REQ-026 When ForwardAE=10 the ALU SHALL use the pre-edge ALUOutM value, giving a back-to-back dependent chain.
REQ-027 When ForwardAE=01 and ForwardBE=10 in the same cycle, each operand SHALL take its own source independently.

Reset
REQ-028 clr_n low SHALL immediately, without waiting for clk, force RegWriteM, MemtoRegM, MemWriteM, OverflowM to 0, ALUOutM and WriteDataM to all zeros, and WriteRegM to 0.
REQ-029 Reset asserted mid-stream SHALL discard the in-flight instruction, so no register or memory write is issued from it.
REQ-030 The first rising clk after clr_n deasserts SHALL capture normally.

Configuration
REQ-031 Macro OVERFLOW_TRAP_EN SHALL control overflow trapping.
REQ-032 With OVERFLOW_TRAP_EN defined, an overflowing add or sub SHALL register OverflowM=1 and SHALL force RegWriteM=0 for that instruction.
REQ-033 Without OVERFLOW_TRAP_EN, OverflowM SHALL be tied 0, RegWriteM SHALL follow RegWriteE unconditionally, and no detection logic SHALL be synthesised.

Verification
REQ-034 Scenario: ALUControlE=010, RD1_E=5, RD2_E=7, ALUSrcE=0, forwards 00 -> next cycle ALUOutM=12, WriteDataM=7.
REQ-035 Scenario: RegDstE=0, RT_E=9, RD_E=3, ALUSrcE=1, SignImmE=0xFFFFFFFC, RD1_E=0x10, op add, MemWriteE=1 -> WriteRegE=9 combinationally; next cycle ALUOutM=0x0C, MemWriteM=1.
REQ-036 Scenario: add 1+1 (ALUOutM=2), then next cycle ForwardAE=10, ForwardBE=01, ResultW=40, op add -> ALUOutM=42.
REQ-037 Scenario: op 111, SrcA=0x80000000, SrcB=0x7FFFFFFF -> ALUOutM=1; swapped operands -> 0.
REQ-038 Scenario: add 0x7FFFFFFF+1, RegWriteE=1 -> with OVERFLOW_TRAP_EN: ALUOutM=0x80000000, OverflowM=1, RegWriteM=0; without it: OverflowM=0, RegWriteM=1.
REQ-039 Scenario: clr_n pulsed low between clk edges while RegWriteM=1 -> all M outputs zero before the next edge and stay zero until the first edge after release.
